// File: rtl/fifo_pkg.sv
// Shared types and helpers for the flagged FIFO family.
package fifo_pkg;

  // Read-side presentation of the head word.
  typedef enum logic {
    FIFO_STD  = 1'b0,  // registered read, one-cycle latency after a pop
    FIFO_FWFT = 1'b1   // head word shown on rd_data without a pop
  } fifo_mode_e;

  // Widest pointer the helper below can compare (wrap bit included).
  localparam int PTR_MAX_W = 32;

  // Pointers carry one wrap bit above the address bits. The FIFO is full when
  // the wrap bits differ and the address bits match, i.e. when the XOR of the
  // two pointers is exactly the wrap bit. Callers zero-extend their pointers
  // and pass the number of address bits in aw.
  function automatic logic ptr_full(input logic [PTR_MAX_W-1:0] wp,
                                    input logic [PTR_MAX_W-1:0] rp,
                                    input int                   aw);
    logic [PTR_MAX_W-1:0] diff;
    diff = wp ^ rp;
    return diff == (PTR_MAX_W'(1) << aw);
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and error-flag control for fifo_flagged.
// Decides which requests are accepted and exposes the storage addresses.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          clear,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic          err_clr,
  output logic          wr_acc,
  output logic          rd_acc,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);

  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] level_reg, level_next;
  logic          overflow_reg, overflow_next;
  logic          underflow_reg, underflow_next;
  logic          wr_req, rd_req;

  // Status decoded straight from the registered pointers.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = ptr_full(PTR_MAX_W'(wr_ptr_reg), PTR_MAX_W'(rd_ptr_reg), AW);

  // A flush swallows both requests, so nothing is accepted or flagged during it.
  // A write into a full FIFO is still taken when a pop frees the slot in the
  // same cycle (pass-through). An empty FIFO never pops, even if a write lands.
  always_comb begin
    wr_req = wr_en & ~clear;
    rd_req = rd_en & ~clear;
    rd_acc = rd_req & ~empty;
    wr_acc = wr_req & (~full | rd_acc);
  end

  // Next pointers, occupancy and sticky error flags.
  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    level_next     = level_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;

    if (clear) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = '0;
    end else begin
      if (wr_acc) wr_ptr_next = wr_ptr_reg + PW'(1);
      if (rd_acc) rd_ptr_next = rd_ptr_reg + PW'(1);
      level_next = level_reg + PW'(wr_acc) - PW'(rd_acc);
    end

    // Clearing first and setting afterwards lets a fresh error win over err_clr.
    if (err_clr) begin
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end
    if (wr_req & ~wr_acc) overflow_next  = 1'b1;
    if (rd_req & ~rd_acc) underflow_next = 1'b1;
  end

  // State register for pointers, occupancy and error flags.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      level_reg     <= level_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  assign wr_addr   = wr_ptr_reg[AW-1:0];
  assign rd_addr   = rd_ptr_reg[AW-1:0];
  assign level     = level_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: rtl/fifo_flagged.sv
// Synchronous elastic buffer with selectable read presentation, live
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_flagged
  import fifo_pkg::*;
#(
  parameter  int DEPTH      = 16,
  parameter  int DATA_WIDTH = 8,
  parameter  int FWFT       = 0,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic [AW:0]           level,
  input  logic [AW:0]           af_thresh,
  input  logic [AW:0]           ae_thresh,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_acc, rd_acc;
  logic [AW-1:0]         wr_addr, rd_addr;

  fifo_ptr_ctrl #(
    .AW (AW)
  ) u_ptr_ctrl (
    .clk       (clk),
    .arst      (arst),
    .clear     (clear),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .err_clr   (err_clr),
    .wr_acc    (wr_acc),
    .rd_acc    (rd_acc),
    .wr_addr   (wr_addr),
    .rd_addr   (rd_addr),
    .level     (level),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Storage write port; contents are never reset. On a full pass-through the
  // write and the pop hit the same slot, and the pop still sees the old word.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_addr] <= wr_data;
  end

  generate
    if (MODE == FIFO_STD) begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_reg;
      logic                  rd_valid_reg, rd_valid_next;

      // One-cycle valid pulse per accepted pop; a flush kills any pending pulse.
      always_comb begin
        rd_valid_next = rd_acc & ~clear;
      end

      // Registered read port; rd_data keeps the last popped word between pops.
      always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
          rd_data_reg  <= '0;
          rd_valid_reg <= 1'b0;
        end else begin
          rd_valid_reg <= rd_valid_next;
          if (rd_acc) rd_data_reg <= mem[rd_addr];
        end
      end

      assign rd_data  = rd_data_reg;
      assign rd_valid = rd_valid_reg;
    end else begin : g_fwft
      // Head word shown combinationally; zero while empty so the unreset
      // storage never leaks onto rd_data.
      assign rd_valid = ~empty;
      assign rd_data  = empty ? '0 : mem[rd_addr];
    end
  endgenerate

  // Thresholds are compared live against the current occupancy.
  assign almost_full  = (level >= af_thresh);
  assign almost_empty = (level <= ae_thresh);

endmodule
